seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 129 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex nibbles from a multiplexed active-low 7-segment bus.
// Revision 1.0 - initial release.
`default_nettype none

module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [6:0]              iSEG,
  input  logic [NUM_DIGITS-1:0]   iDIG_SEL,
  output logic [4*NUM_DIGITS-1:0] oHEX,
  output logic                    oVALID,
  output logic [NUM_DIGITS-1:0]   oERR_MASK,
  output logic [NUM_DIGITS-1:0]   oBLANK_MASK,
  output logic                    oERR
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [NUM_DIGITS-1:0]   s_sel, p_sel;
  logic [6:0]              s_seg, p_seg;
  logic [CW-1:0]           cnt;
  logic [0:0]              state;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] shadow_hex;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic                    same;
  logic                    stable;
  logic [NUM_DIGITS-1:0]   cap_vec;
  logic                    commit;
  logic [3:0]              dec_nib;
  logic                    dec_err;
  logic                    dec_blank;

  assign same    = (s_sel == p_sel) && (s_seg == p_seg);
  assign stable  = (state == ST_WAIT) && same && (cnt == CNT_LAST);
  // Zero or multi-hot selects still consume the stable period, just without a capture.
  assign cap_vec = (stable && $onehot(s_sel)) ? s_sel : '0;
  assign commit  = &seen;

  always_comb begin
    dec_nib   = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (s_seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s_sel        <= '0;
      s_seg        <= '0;
      p_sel        <= '0;
      p_seg        <= '0;
      cnt          <= '0;
      state        <= ST_WAIT;
      seen         <= '0;
      shadow_hex   <= '0;
      shadow_err   <= '0;
      shadow_blank <= '0;
      oHEX         <= '0;
      oVALID       <= 1'b0;
      oERR_MASK    <= '0;
      oBLANK_MASK  <= '0;
      oERR         <= 1'b0;
    end else begin
      s_sel <= iDIG_SEL;
      s_seg <= iSEG;
      p_sel <= s_sel;
      p_seg <= s_seg;

      if (!same) begin
        cnt   <= '0;
        state <= ST_WAIT;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (stable) state <= ST_HOLD;
      end

      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_vec[k]) begin
          shadow_hex[4*k +: 4] <= dec_nib;
          shadow_err[k]        <= dec_err;
          shadow_blank[k]      <= dec_blank;
        end
      end

      // A capture landing on the commit cycle starts the next frame.
      seen   <= (commit ? '0 : seen) | cap_vec;
      oVALID <= commit;
      if (commit) begin
        oHEX        <= shadow_hex;
        oERR_MASK   <= shadow_err;
        oBLANK_MASK <= shadow_blank;
        oERR        <= |shadow_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench for seg7_scan_decoder with a frame-level reference model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig_sel = 4'h0;
  logic [15:0] hex;
  logic        valid;
  logic [3:0]  err_mask;
  logic [3:0]  blank_mask;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .iCLK(clk), .iRST(rst), .iSEG(seg), .iDIG_SEL(dig_sel),
    .oHEX(hex), .oVALID(valid), .oERR_MASK(err_mask),
    .oBLANK_MASK(blank_mask), .oERR(err)
  );

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  em;
    logic [3:0]  bm;
  } frame_t;

  frame_t exp_q[$];

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: a held pattern of at least 6 cycles on a one-hot select is one capture.
  logic [3:0]  m_nib [4];
  logic [3:0]  m_err, m_blank, m_seen;
  logic [10:0] last_in = '0;

  task automatic classify(input logic [6:0] g, output logic [3:0] nib, output logic e, output logic b);
    nib = 4'h0;
    e   = 1'b1;
    b   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (codes[i] == g) begin
        nib = 4'(i);
        e   = 1'b0;
      end
    end
    if (g == 7'h7F) begin
      e = 1'b0;
      b = 1'b1;
    end
  endtask

  task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
    logic [3:0] nib;
    logic e, b;
    frame_t f;
    int k;
    if (n >= 6 && $countones(s) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (s[i]) k = i;
      classify(g, nib, e, b);
      m_nib[k]   = nib;
      m_err[k]   = e;
      m_blank[k] = b;
      m_seen[k]  = 1'b1;
      if (m_seen == 4'hF) begin
        f.hex = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        f.em  = m_err;
        f.bm  = m_blank;
        exp_q.push_back(f);
        m_seen = 4'h0;
      end
    end
    dig_sel = s;
    seg     = g;
    last_in = {s, g};
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
    hold(4'b0001, g0, 8);
    hold(4'b0010, g1, 8);
    hold(4'b0100, g2, 8);
    hold(4'b1000, g3, 8);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      @(negedge clk);
      b++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected frames never committed (required 0)", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (hex !== 16'h0 || valid !== 1'b0 || err_mask !== 4'h0 || blank_mask !== 4'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s: hex=%h valid=%b err_mask=%b blank_mask=%b err=%b, required all zero",
               name, hex, valid, err_mask, blank_mask, err);
    end
  endtask

  // Monitor: every oVALID pulse pops one expected frame.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (valid === 1'b1) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_gap: valid high two consecutive cycles, required a low cycle between");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: hex=%h err_mask=%b blank_mask=%b, required no commit", hex, err_mask, blank_mask);
      end else begin
        f = exp_q.pop_front();
        if (hex !== f.hex || err_mask !== f.em || blank_mask !== f.bm || err !== (|f.em)) begin
          bad++;
          $display("FAIL frame: got hex=%h err_mask=%b blank_mask=%b err=%b, required hex=%h err_mask=%b blank_mask=%b err=%b",
                   hex, err_mask, blank_mask, err, f.hex, f.em, f.bm, |f.em);
        end
      end
    end
    prev_valid = (valid === 1'b1);
  end

  initial begin
    logic [3:0] s;
    logic [6:0] g;
    int n, kind;

    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_err = 4'h0; m_blank = 4'h0; m_seen = 4'h0;

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Basic scan, error/blank scan, glitch filter.
    scan4(7'h30, 7'h19, 7'h00, 7'h0E);
    drain();
    scan4(7'h30, 7'h55, 7'h7F, 7'h30);
    drain();
    hold(4'b0001, 7'h24, 3);
    hold(4'b0001, 7'h79, 8);
    hold(4'b0010, 7'h40, 8);
    hold(4'b0100, 7'h40, 8);
    hold(4'b1000, 7'h40, 8);
    drain();

    // Illegal selects never capture, then a legal scan.
    hold(4'b0011, 7'h24, 10);
    hold(4'b0000, 7'h30, 10);
    scan4(7'h12, 7'h02, 7'h78, 7'h10);
    drain();

    // Reset mid-frame drops partial captures.
    hold(4'b0001, 7'h08, 8);
    hold(4'b0010, 7'h03, 8);
    dig_sel = 4'h0;
    seg     = 7'h7F;
    rst     = 1'b1;
    m_seen  = 4'h0;
    last_in = {4'h0, 7'h7F};
    @(negedge clk);
    check_zero("during_reset");
    rst = 1'b0;
    hold(4'b0001, 7'h40, 8);
    check_zero("after_reset");
    hold(4'b0010, 7'h40, 8);
    hold(4'b0100, 7'h40, 8);
    hold(4'b1000, 7'h40, 8);
    drain();

    // Overwrite of a slot before the frame completes, then back-to-back frames.
    hold(4'b0001, 7'h06, 8);
    hold(4'b0001, 7'h46, 8);
    scan4(7'h46, 7'h21, 7'h03, 7'h08);
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    drain();

    // Randomized segments: legal holds, short glitches, illegal selects.
    for (int t = 0; t < 120; t++) begin
      do begin
        kind = $urandom_range(0, 9);
        if (kind < 7) s = 4'(1 << $urandom_range(0, 3));
        else if (kind == 7) s = 4'($urandom_range(0, 15));
        else s = 4'(1 << $urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0:       g = 7'($urandom_range(0, 127));
          1:       g = 7'h7F;
          default: g = codes[$urandom_range(0, 15)];
        endcase
      end while ({s, g} == last_in);
      n = (kind >= 8) ? $urandom_range(1, 4) : $urandom_range(6, 11);
      hold(s, g, n);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
